// File: rtl/efuse_seq_ctrl.sv
// efuse_seq_ctrl: eFuse power-switch, program, read and verify sequencer
module efuse_seq_ctrl #(
    parameter int NBITS  = 32,
    parameter int T_RAMP = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic [3:0]       tckhp,
    input  logic [NBITS-1:0] prog,
    input  logic             dout,
    output logic             en,
    output logic             rampena,
    output logic             short,
    output logic             csb,
    output logic             pgm,
    output logic             sclk,
    output logic [NBITS-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int TW = (T_RAMP > 16) ? $clog2(T_RAMP) : 4;

    typedef enum logic [3:0] {
        IDLE, PWR_EN, PWR_RAMP, PRG_HI, PRG_LO, PWR_DN, RD_HI, RD_LO, CHECK, DONE
    } state_t;

    state_t           state, state_nx;
    logic [TW-1:0]    cnt;
    logic [BW-1:0]    bit_idx;
    logic [1:0]       mode_r;
    logic [NBITS-1:0] prog_r;
    logic             start_d;
    logic             accept;
    logic             last;
    logic             ramp_end;

    assign accept   = state == IDLE && start && !start_d && mode != 2'b00;
    assign last     = bit_idx == BW'(NBITS - 1);
    assign ramp_end = cnt == TW'(T_RAMP - 1);

    // next-state sequencing; cnt times the dwell in the current state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = accept ? (mode == 2'b10 ? RD_HI : PWR_EN) : IDLE;
            PWR_EN:   state_nx = ramp_end ? PWR_RAMP : PWR_EN;
            PWR_RAMP: state_nx = ramp_end ? PRG_HI : PWR_RAMP;
            PRG_HI:   state_nx = cnt == TW'(tckhp) ? PRG_LO : PRG_HI;
            PRG_LO:   state_nx = cnt[0] ? (last ? PWR_DN : PRG_HI) : PRG_LO;
            PWR_DN:   state_nx = ramp_end ? (mode_r == 2'b11 ? RD_HI : CHECK) : PWR_DN;
            RD_HI:    state_nx = RD_LO;
            RD_LO:    state_nx = last ? CHECK : RD_HI;
            CHECK:    state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // state, timers, latched request, read-back register and verify flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            mode_r  <= '0;
            prog_r  <= '0;
            q       <= '0;
            err     <= 1'b0;
            start_d <= 1'b1;  // a start still high after reset must drop before it counts
        end else begin
            state   <= state_nx;
            start_d <= start;
            cnt     <= (state_nx == state && state != IDLE) ? cnt + 1'b1 : '0;
            if (state == IDLE || state == PWR_DN)
                bit_idx <= '0;
            else if ((state == PRG_LO || state == RD_LO) && state_nx != state && !last)
                bit_idx <= bit_idx + 1'b1;
            if (accept) begin
                mode_r <= mode;
                prog_r <= prog;
                err    <= 1'b0;
            end
            if (state == RD_HI)
                q[bit_idx] <= dout;
            if (state == CHECK)
                err <= mode_r == 2'b11 && q != prog_r;
        end
    end

    // Moore outputs decoded from the state
    always_comb begin
        en      = state inside {PWR_EN, PWR_RAMP, PRG_HI, PRG_LO, PWR_DN};
        rampena = state inside {PWR_RAMP, PRG_HI, PRG_LO};
        short   = !en;
        csb     = !(state inside {PRG_HI, PRG_LO, RD_HI, RD_LO});
        sclk    = state inside {PRG_HI, RD_HI};
        pgm     = state == PRG_HI && prog_r[bit_idx];
        busy    = !(state inside {IDLE, DONE});
        done    = state == DONE;
    end
endmodule

// File: tb/tb_efuse_seq_ctrl.sv
// tb_efuse_seq_ctrl: randomized self-checking bench with an eFuse macro model
module tb_efuse_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [3:0]  tckhp = 4'd0;
    logic [31:0] prog = 32'h0;
    logic        dout;
    logic        en, rampena, short, csb, pgm, sclk, busy, done, err;
    logic [31:0] q;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] q_ref = 32'h0;

    always #5 clk = ~clk;

    efuse_seq_ctrl #(.NBITS(32), .T_RAMP(16)) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .tckhp(tckhp),
        .prog(prog), .dout(dout), .en(en), .rampena(rampena), .short(short),
        .csb(csb), .pgm(pgm), .sclk(sclk), .q(q), .busy(busy), .done(done), .err(err)
    );

    logic [63:0] fuse_init = '0;
    logic [63:0] stuck = '0;
    logic [63:0] burned = '0;
    logic [5:0]  idx = '0;
    int chip = 0, chip_seen = 0;
    int cyc = 0, rises_p = 0, rises_r = 0, pgm_pulses = 0, bad_hi = 0;
    int viol = 0, en_cyc = 0, act_cyc = 0, done_cnt = 0, run = 0;
    logic prev_s = 1'b0, pulse_en = 1'b0, pulse_pgm = 1'b0;

    assign dout = (fuse_init[idx] | burned[idx]) & ~stuck[idx];

    // macro model and activity monitor, sampling the cycle that just ended
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if ((en && short) || (rampena && !en) || (pgm && (!rampena || csb))) viol <= viol + 1;
        if (en) en_cyc <= en_cyc + 1;
        if (busy || !csb || sclk || en || rampena || pgm || done) act_cyc <= act_cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (sclk && !prev_s) begin
            run <= 1;
            pulse_en <= en;
            pulse_pgm <= pgm;
            if (en) rises_p <= rises_p + 1;
            else rises_r <= rises_r + 1;
        end else if (sclk) begin
            run <= run + 1;
            pulse_pgm <= pulse_pgm | pgm;
        end
        if (!sclk && prev_s) begin
            if (run != (pulse_en ? int'(tckhp) + 1 : 1)) bad_hi <= bad_hi + 1;
            if (pulse_pgm) pgm_pulses <= pgm_pulses + 1;
        end
        prev_s <= sclk;
        if (chip != chip_seen) begin
            burned <= '0;
            chip_seen <= chip;
        end else if (sclk && pgm && en) burned[idx] <= 1'b1;
        if (csb) idx <= '0;
        else if (prev_s && !sclk) idx <= idx + 1'b1;
    end

    // issue one request and return the accept-to-done latency (-1 on timeout)
    task automatic do_op(input logic [1:0] m, input logic [31:0] p, input logic [3:0] k, output int lat);
        int t0;
        @(negedge clk);
        mode = m; prog = p; tckhp = k; start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int i = 0; i < 1500; i++) begin
            if (done) begin lat = cyc - t0; break; end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; mode = 2'b10; start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({en, rampena, short, csb, pgm, sclk, busy, done, err} !== 9'b001100000) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", {en, rampena, short, csb, pgm, sclk, busy, done, err}, 9'b001100000); end
        n_cmp++; if (q !== 32'h0) begin n_fail++; $display("FAIL reset_q: got %h want 0", q); end
        start = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++; if ({busy, en, csb} !== 3'b001) begin n_fail++; $display("FAIL start_held_over_reset: got busy/en/csb %b want 001", {busy, en, csb}); end
        start = 1'b0;
        @(negedge clk);
        q_ref = 32'h0;
    endtask

    task automatic test_read();
        int lat, d_done, d_rr, d_rp, d_en, d_bad;
        chip++; fuse_init = 64'hA5A55A5A; stuck = '0;
        d_done = done_cnt; d_rr = rises_r; d_rp = rises_p; d_en = en_cyc; d_bad = bad_hi;
        do_op(2'b10, $urandom, 4'd1, lat);
        n_cmp++; if (lat !== 66) begin n_fail++; $display("FAIL read_latency: got %0d want 66", lat); end
        n_cmp++; if (q !== 32'hA5A55A5A) begin n_fail++; $display("FAIL read_q: got %h want a5a55a5a", q); end
        n_cmp++; if (rises_r - d_rr !== 32 || rises_p - d_rp !== 0) begin n_fail++; $display("FAIL read_pulses: got rd %0d prg %0d want 32 0", rises_r - d_rr, rises_p - d_rp); end
        n_cmp++; if (en_cyc - d_en !== 0 || bad_hi - d_bad !== 0) begin n_fail++; $display("FAIL read_power_or_width: en cycles %0d bad widths %0d want 0 0", en_cyc - d_en, bad_hi - d_bad); end
        n_cmp++; if (done_cnt - d_done !== 1 || err !== 1'b0) begin n_fail++; $display("FAIL read_done_err: done %0d err %b want 1 0", done_cnt - d_done, err); end
        q_ref = 32'hA5A55A5A;
    endtask

    task automatic test_program();
        int lat, d_rp, d_pg, d_bad, d_viol;
        chip++; fuse_init = '0; stuck = '0;
        d_rp = rises_p; d_pg = pgm_pulses; d_bad = bad_hi; d_viol = viol;
        do_op(2'b01, 32'hA5A55A5A, 4'd1, lat);
        n_cmp++; if (lat !== 178) begin n_fail++; $display("FAIL prog_latency: got %0d want 178", lat); end
        n_cmp++; if (rises_p - d_rp !== 32 || pgm_pulses - d_pg !== 16) begin n_fail++; $display("FAIL prog_pulses: sclk %0d pgm %0d want 32 16", rises_p - d_rp, pgm_pulses - d_pg); end
        n_cmp++; if (bad_hi - d_bad !== 0 || viol - d_viol !== 0) begin n_fail++; $display("FAIL prog_width_or_power: bad widths %0d violations %0d want 0 0", bad_hi - d_bad, viol - d_viol); end
        n_cmp++; if (q !== q_ref || err !== 1'b0) begin n_fail++; $display("FAIL prog_q_held: q %h err %b want %h 0", q, err, q_ref); end
        do_op(2'b10, 32'h0, 4'd1, lat);
        n_cmp++; if (q !== 32'hA5A55A5A || lat !== 66) begin n_fail++; $display("FAIL prog_readback: q %h lat %0d want a5a55a5a 66", q, lat); end
        q_ref = 32'hA5A55A5A;
    endtask

    task automatic test_verify();
        int lat;
        chip++; fuse_init = '0; stuck = 64'h1 << 16;
        do_op(2'b11, 32'hFFFF0000, 4'd1, lat);
        n_cmp++; if (lat !== 242) begin n_fail++; $display("FAIL verify_latency: got %0d want 242", lat); end
        n_cmp++; if (err !== 1'b1 || q !== 32'hFFFE0000) begin n_fail++; $display("FAIL verify_stuck: err %b q %h want 1 fffe0000", err, q); end
        repeat (5) @(negedge clk);
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL verify_err_held: got %b want 1", err); end
        chip++; stuck = '0;
        do_op(2'b11, 32'hFFFF0000, 4'd1, lat);
        n_cmp++; if (err !== 1'b0 || q !== 32'hFFFF0000 || lat !== 242) begin n_fail++; $display("FAIL verify_clean: err %b q %h lat %0d want 0 ffff0000 242", err, q, lat); end
        q_ref = 32'hFFFF0000;
    endtask

    task automatic test_back_to_back();
        int lat, t0, d_done, d_rr;
        logic [31:0] p;
        chip++; fuse_init = {32'h0, $urandom}; stuck = '0; p = $urandom;
        d_done = done_cnt; d_rr = rises_r;
        @(negedge clk);
        mode = 2'b01; prog = p; tckhp = 4'd1; start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            if (i == 10 || i == 60) begin mode = 2'b10; start = 1'b1; end
            else if (i == 11 || i == 61) start = 1'b0;
            if (done && lat < 0) lat = cyc - t0;
            @(negedge clk);
        end
        n_cmp++; if (lat !== 178 || done_cnt - d_done !== 1) begin n_fail++; $display("FAIL busy_ignore: lat %0d dones %0d want 178 1", lat, done_cnt - d_done); end
        n_cmp++; if (rises_r - d_rr !== 0) begin n_fail++; $display("FAIL busy_ignore_read: read pulses %0d want 0", rises_r - d_rr); end
        d_done = done_cnt;
        mode = 2'b10; start = 1'b1;
        repeat (300) @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (done_cnt - d_done !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL start_held: dones %0d busy %b want 1 0", done_cnt - d_done, busy); end
        n_cmp++; if (q !== (fuse_init[31:0] | p)) begin n_fail++; $display("FAIL start_held_q: got %h want %h", q, fuse_init[31:0] | p); end
        q_ref = fuse_init[31:0] | p;
    endtask

    task automatic test_mode00_tckhp0();
        int lat, d_act, d_done, d_bad, d_rp, d_pg;
        logic [31:0] p;
        d_act = act_cyc; d_done = done_cnt;
        @(negedge clk);
        mode = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (act_cyc - d_act !== 0 || done_cnt - d_done !== 0) begin n_fail++; $display("FAIL mode00: active cycles %0d dones %0d want 0 0", act_cyc - d_act, done_cnt - d_done); end
        chip++; fuse_init = '0; stuck = '0; p = $urandom;
        d_bad = bad_hi; d_rp = rises_p; d_pg = pgm_pulses;
        do_op(2'b01, p, 4'd0, lat);
        n_cmp++; if (lat !== 146) begin n_fail++; $display("FAIL tckhp0_latency: got %0d want 146", lat); end
        n_cmp++; if (bad_hi - d_bad !== 0 || rises_p - d_rp !== 32) begin n_fail++; $display("FAIL tckhp0_width: bad widths %0d pulses %0d want 0 32", bad_hi - d_bad, rises_p - d_rp); end
        n_cmp++; if (pgm_pulses - d_pg !== $countones(p)) begin n_fail++; $display("FAIL tckhp0_pgm: got %0d want %0d", pgm_pulses - d_pg, $countones(p)); end
    endtask

    task automatic test_reset_mid();
        logic found;
        chip++; fuse_init = '0; stuck = '0;
        @(negedge clk);
        mode = 2'b11; prog = $urandom | 32'h1; tckhp = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sclk && en) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL reset_mid_reach: prg_hi seen %b want 1", found); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({en, short, csb, pgm, sclk, busy, rampena, done} !== 8'b01100000) begin n_fail++; $display("FAIL reset_mid_outputs: got %b want 01100000", {en, short, csb, pgm, sclk, busy, rampena, done}); end
        n_cmp++; if (q !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_mid_regs: q %h err %b want 0 0", q, err); end
        rst = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_resume: busy %b want 0", busy); end
        q_ref = 32'h0;
    endtask

    task automatic test_random();
        int lat, exp_lat, d_pg;
        logic [1:0]  m;
        logic [3:0]  k;
        logic [31:0] p, q_exp;
        logic [63:0] cells;
        logic        err_exp;
        for (int n = 0; n < 8; n++) begin
            m = 2'($urandom_range(1, 3));
            k = 4'($urandom_range(0, 3));
            p = $urandom;
            chip++;
            fuse_init = {32'h0, $urandom};
            stuck = $urandom_range(0, 1) ? (64'h1 << $urandom_range(0, 31)) : 64'h0;
            cells = (fuse_init | (m != 2'b10 ? {32'h0, p} : 64'h0)) & ~stuck;
            exp_lat = (m == 2'b10 ? 0 : 3 * 16 + 32 * (int'(k) + 3) + 2) + (m == 2'b01 ? 0 : 66) - (m == 2'b11 ? 2 : 0);
            q_exp = m == 2'b01 ? q_ref : cells[31:0];
            err_exp = m == 2'b11 && q_exp != p;
            d_pg = pgm_pulses;
            do_op(m, p, k, lat);
            n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rand_latency[%0d] mode %0d: got %0d want %0d", n, m, lat, exp_lat); end
            n_cmp++; if (q !== q_exp || err !== err_exp) begin n_fail++; $display("FAIL rand_result[%0d] mode %0d: q %h err %b want %h %b", n, m, q, err, q_exp, err_exp); end
            n_cmp++; if (pgm_pulses - d_pg !== (m == 2'b10 ? 0 : $countones(p))) begin n_fail++; $display("FAIL rand_pgm[%0d]: got %0d want %0d", n, pgm_pulses - d_pg, m == 2'b10 ? 0 : $countones(p)); end
            q_ref = q_exp;
        end
    endtask

    // scenario sequence
    initial begin
        test_reset();
        test_read();
        test_program();
        test_verify();
        test_back_to_back();
        test_mode00_tckhp0();
        test_reset_mid();
        test_random();
        n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL power_invariants: violations %0d want 0", viol); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/efuse_seq_ctrl.md
EFUSE_SEQ_CTRL -- requirements
Module: efuse_seq_ctrl

Interface
REQ-001 Parameter NBITS, default 32, number of eFuse bits programmed/read (1..64).
REQ-002 Parameter T_RAMP, default 16, power-switch settle time in clk cycles (>=1).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 mode  input  2  01 program, 10 read, 11 program-then-verify, 00 no-op.
REQ-006 start  input  1  operation request, rising-edge detected.
REQ-007 tckhp  input  4  SCLK high length during programming = tckhp+1 cycles.
REQ-008 prog  input  NBITS  data to burn; bit i burned iff prog[i]=1.
REQ-009 dout  input  1  serial read data from eFuse macro.
REQ-010 en, rampena, short  output  1 each  power-switch controls.
REQ-011 csb, pgm, sclk  output  1 each  eFuse chip select (low active), program enable, serial clock.
REQ-012 q  output  NBITS  read-back data register.
REQ-013 busy, done, err  output  1 each  operation active, 1-cycle completion pulse, verify mismatch.

Function
REQ-014 Start accepted only in IDLE when start=1 and previous-cycle start=0 and mode!=00; mode and prog latched on the accept edge; busy=1 from the next cycle.
REQ-015 start edges while busy, or with mode=00, shall be ignored; start held high counts once.
REQ-016 States: IDLE, PWR_EN, PWR_RAMP, PRG_HI, PRG_LO, PWR_DN, RD_HI, RD_LO, CHECK, DONE.
REQ-017 IDLE outputs: csb=1, pgm=0, sclk=0, en=0, rampena=0, short=1, busy=0, done=0.
REQ-018 Program path (mode 01/11): PWR_EN T_RAMP cycles (en=1, short=0), then PWR_RAMP T_RAMP cycles (also rampena=1).
REQ-019 Per bit i=0..NBITS-1 ascending: PRG_HI tckhp+1 cycles with csb=0, sclk=1, pgm=prog[i]; PRG_LO 2 cycles with sclk=0, pgm=0, csb=0.
REQ-020 tckhp=0 gives a 1-cycle SCLK high; tckhp is sampled live, must be held stable while busy.
REQ-021 After last bit: PWR_DN T_RAMP cycles with rampena=0, csb=1, en=1, short=0; en=0 and short=1 on exit.
REQ-022 en=1 and short=1 never simultaneously; rampena=1 only while en=1; pgm=1 only while rampena=1 and csb=0.
REQ-023 Read path (mode 10, or 11 after PWR_DN): power switch off, csb=0, pgm=0; per bit i ascending RD_HI 1 cycle (sclk=1) then RD_LO 1 cycle; q[i] loaded from dout at the end of RD_HI.
REQ-024 q bits not yet read retain previous values; q is not cleared by start.
REQ-025 CHECK 1 cycle, csb=1; mode 11: err <= (q != latched prog); other modes err=0.
REQ-026 DONE 1 cycle: done=1, busy=0; next state IDLE.
REQ-027 err cleared on next accepted start, otherwise held.
REQ-028 Latency (accept edge = cycle 0): done high in cycle 3*T_RAMP+NBITS*(tckhp+3)+2 (mode 01), 2*NBITS+2 (mode 10), sum of both minus 2 (mode 11).
REQ-029 Bit counter sized ceil(log2(NBITS)), no wrap beyond NBITS-1.

Reset
REQ-030 rst=0 at any clock edge, including mid-operation: state IDLE, outputs per REQ-017, q=0, err=0, start edge detector cleared, latched data cleared.
REQ-031 After rst releases, start already high shall not be accepted until it drops and rises again.

Verification
REQ-032 rst=0 mid-PRG_HI (NBITS=32) -> next edge en=0, short=1, csb=1, pgm=0, sclk=0, busy=0.
REQ-033 NBITS=32, T_RAMP=16, tckhp=1, mode=01, prog=0xA5A55A5A -> 32 SCLK pulses each 2 cycles high, pgm high in exactly 16 of them (bits 1,3,4,6,...), done in cycle 178.
REQ-034 mode=10, eFuse model holding 0xA5A55A5A -> q=0xA5A55A5A, 32 SCLK pulses of 1 cycle, done in cycle 66, en=0 throughout.
REQ-035 mode=11, prog=0xFFFF0000, model with bit 16 stuck at 0 -> err=1 with done in cycle 242; fault removed and repeated -> err=0.
REQ-036 start pulsed during busy, and start held high 300 cycles -> exactly one operation and one done pulse.
REQ-037 mode=00 start, and tckhp=0 program run -> no activity for 00; SCLK high exactly 1 cycle per bit for tckhp=0.
